// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
// Latches a transmit request, sequences start / data (LSB first) / optional
// parity / stop bits on baud ticks, drives the serializer load strobe and bit
// index, and muxes the serializer's registered bit into the TX line.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          tx_start,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          par_en,
    input  logic                          par_type,
    input  logic                          serial_data,
    output logic [DATA_WIDTH-1:0]         parallel_data,
    output logic                          ser_en,
    output logic [$clog2(DATA_WIDTH)-1:0] frame,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int FRAME_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Index of the last data bit and of the last stop bit.
    localparam logic [FRAME_W-1:0] LAST_BIT  = FRAME_W'(DATA_WIDTH - 32'sd1);
    localparam logic               STOP_LAST = (STOP_BITS == 32'sd2) ? 1'b1 : 1'b0;
    localparam logic [FRAME_W-1:0] BIT_ONE   = FRAME_W'(1'b1);

    // Parity bit for a word: even parity for odd_sel=0, odd parity for odd_sel=1.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  odd_sel);
        return (^data) ^ odd_sel;
    endfunction

    logic [2:0]            state_r,    state_s;
    logic [FRAME_W-1:0]    bit_cnt_r,  bit_cnt_s;
    logic                  stop_cnt_r, stop_cnt_s;
    logic [DATA_WIDTH-1:0] data_r,     data_s;
    logic                  parity_r,   parity_s;
    logic                  par_en_r,   par_en_s;
    logic                  tx_done_r,  tx_done_s;
    logic                  ser_en_s;
    logic [FRAME_W-1:0]    frame_s;
    logic                  tx_out_s;

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        data_s     = data_r;
        parity_s   = parity_r;
        par_en_s   = par_en_r;
        tx_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A tick coinciding with the accept is deliberately ignored;
                // ALIGN waits for the next one so START is a full bit period.
                if (tx_start) begin
                    data_s   = tx_data;
                    par_en_s = par_en;
                    parity_s = calc_parity(tx_data, par_type);
                    state_s  = ST_ALIGN;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (baud_tick) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_ALIGN;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    bit_cnt_s = {FRAME_W{1'b0}};
                    state_s   = ST_DATA;
                end else begin
                    state_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_r != LAST_BIT) begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end else if (par_en_r) begin
                        state_s = ST_PARITY;
                    end else begin
                        stop_cnt_s = 1'b0;
                        state_s    = ST_STOP;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    stop_cnt_s = 1'b0;
                    state_s    = ST_STOP;
                end else begin
                    state_s    = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_r != STOP_LAST) begin
                        stop_cnt_s = 1'b1;
                    end else begin
                        tx_done_s = 1'b1;
                        state_s   = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Serializer load strobe: bit 0 on the START tick, bit n+1 on DATA tick n.
    always_comb begin
        ser_en_s = 1'b0;
        frame_s  = {FRAME_W{1'b0}};
        case (state_r)
            ST_START: begin
                if (baud_tick) begin
                    ser_en_s = 1'b1;
                end else begin
                    ser_en_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_tick && (bit_cnt_r != LAST_BIT)) begin
                    ser_en_s = 1'b1;
                    frame_s  = bit_cnt_r + BIT_ONE;
                end else begin
                    ser_en_s = 1'b0;
                end
            end
            default: begin
                ser_en_s = 1'b0;
            end
        endcase
    end

    // TX line mux; every selector and source here is a register.
    always_comb begin
        tx_out_s = 1'b1;
        case (state_r)
            ST_IDLE:   tx_out_s = 1'b1;
            ST_ALIGN:  tx_out_s = 1'b1;
            ST_START:  tx_out_s = 1'b0;
            ST_DATA:   tx_out_s = serial_data;
            ST_PARITY: tx_out_s = parity_r;
            ST_STOP:   tx_out_s = 1'b1;
            default:   tx_out_s = 1'b1;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any frame.
    always_ff @(posedge UCLK) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {FRAME_W{1'b0}};
            stop_cnt_r <= 1'b0;
            data_r     <= {DATA_WIDTH{1'b0}};
            parity_r   <= 1'b0;
            par_en_r   <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            data_r     <= data_s;
            parity_r   <= parity_s;
            par_en_r   <= par_en_s;
            tx_done_r  <= tx_done_s;
        end
    end

    assign parallel_data = data_r;
    assign ser_en        = ser_en_s;
    assign frame         = frame_s;
    assign tx_out        = tx_out_s;
    assign tx_busy       = (state_r != ST_IDLE);
    assign tx_done       = tx_done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one 8N1 instance and one 8N2 instance,
// each with a behavioural serializer registering parallel_data[frame] on ser_en.
module tb_uart_tx_ctrl;

    logic       UCLK = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       tx_start_a, tx_start_b;
    logic [7:0] tx_data;
    logic       par_en, par_type;

    logic       ser_a = 1'b1, ser_b = 1'b1;
    logic [7:0] pd_a, pd_b;
    logic       sen_a, sen_b;
    logic [2:0] frm_a, frm_b;
    logic       out_a, out_b, busy_a, busy_b, done_a, done_b;

    logic       sel_b;
    logic [7:0] m_pd;
    logic       m_sen, m_out, m_busy, m_done;
    logic [2:0] m_frm;

    int n_cmp = 0;
    int n_err = 0;
    int phase = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .UCLK(UCLK), .reset(reset), .baud_tick(baud_tick), .tx_start(tx_start_a),
        .tx_data(tx_data), .par_en(par_en), .par_type(par_type), .serial_data(ser_a),
        .parallel_data(pd_a), .ser_en(sen_a), .frame(frm_a), .tx_out(out_a),
        .tx_busy(busy_a), .tx_done(done_a));

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .UCLK(UCLK), .reset(reset), .baud_tick(baud_tick), .tx_start(tx_start_b),
        .tx_data(tx_data), .par_en(par_en), .par_type(par_type), .serial_data(ser_b),
        .parallel_data(pd_b), .ser_en(sen_b), .frame(frm_b), .tx_out(out_b),
        .tx_busy(busy_b), .tx_done(done_b));

    always #5 UCLK = ~UCLK;

    // Serializer models: register the indexed bit on each load strobe.
    always @(posedge UCLK) begin
        if (sen_a) ser_a <= pd_a[frm_a];
        if (sen_b) ser_b <= pd_b[frm_b];
    end

    assign m_pd   = sel_b ? pd_b   : pd_a;
    assign m_sen  = sel_b ? sen_b  : sen_a;
    assign m_frm  = sel_b ? frm_b  : frm_a;
    assign m_out  = sel_b ? out_b  : out_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_done = sel_b ? done_b : done_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; baud_tick is high every fourth cycle.
    task automatic cyc();
        @(posedge UCLK);
        #1;
        phase     = (phase + 1) % 4;
        baud_tick = (phase == 0);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            chk("idle_done", m_done, 0);
            chk("idle_busy", m_busy, 0);
            chk("idle_out", m_out, 1);
        end
    endtask

    // Send one frame and check the line bit by bit. Returns in the tx_done cycle.
    task automatic send(input logic b, input logic [7:0] d, input logic pe, input logic pt,
                        input logic ep, input logic sync_tick, input logic inject,
                        input logic abort);
        logic [11:0] bits;
        int nb;
        int na;
        sel_b   = b;
        bits    = 12'h000;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        nb = 9;
        if (pe) begin bits[nb] = ep; nb++; end
        for (int s = 0; s < (b ? 2 : 1); s++) begin bits[nb] = 1'b1; nb++; end

        if (sync_tick) begin
            for (int w = 0; w < 8 && !baud_tick; w++) cyc();
        end
        tx_data = d; par_en = pe; par_type = pt;
        if (b) tx_start_b = 1'b1; else tx_start_a = 1'b1;
        cyc();
        tx_start_a = 1'b0; tx_start_b = 1'b0;
        tx_data = ~d; par_en = ~pe; par_type = ~pt;

        na = 0;
        for (int k = 1; k <= 8; k++) begin
            na = k;
            if (k == 1) begin
                chk("align_done_low", m_done, 0);
                chk("latched_data", m_pd, d);
            end
            chk("align_out", m_out, 1);
            chk("align_busy", m_busy, 1);
            chk("align_ser_en", m_sen, 0);
            if (baud_tick) break;
            cyc();
        end
        chk("align_tick_bound", baud_tick, 1);
        if (sync_tick) chk("align_len", na, 4);

        for (int i = 0; i < nb; i++) begin
            for (int c = 1; c <= 4; c++) begin
                cyc();
                tx_start_a = 1'b0; tx_start_b = 1'b0;
                if (abort && i == 4 && c == 2) begin
                    reset = 1'b0;
                    cyc();
                    reset = 1'b1;
                    chk("abort_out", m_out, 1);
                    chk("abort_busy", m_busy, 0);
                    chk("abort_ser_en", m_sen, 0);
                    chk("abort_frame", m_frm, 0);
                    chk("abort_pdata", m_pd, 0);
                    chk("abort_done", m_done, 0);
                    return;
                end
                chk("bit_out", m_out, bits[i]);
                chk("bit_busy", m_busy, 1);
                chk("bit_done", m_done, 0);
                if (baud_tick && i < 8) begin
                    chk("ser_en_on", m_sen, 1);
                    chk("frame_idx", m_frm, i);
                end else begin
                    chk("ser_en_off", m_sen, 0);
                end
                if (inject && i == 3 && c == 2) begin
                    tx_data = 8'hFF;
                    if (b) tx_start_b = 1'b1; else tx_start_a = 1'b1;
                end
            end
        end
        cyc();
        chk("done_pulse", m_done, 1);
        chk("done_busy", m_busy, 0);
        chk("done_out", m_out, 1);
        chk("done_ser_en", m_sen, 0);
    endtask

    initial begin
        reset = 1'b0; baud_tick = 1'b0; tx_start_a = 1'b0; tx_start_b = 1'b0;
        tx_data = 8'h00; par_en = 1'b0; par_type = 1'b0; sel_b = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_out", out_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_ser_en", sen_a, 0);
        chk("rst_frame", frm_a, 0);
        chk("rst_pdata", pd_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy_b", busy_b, 0);
        reset = 1'b1;
        cyc();

        // 8N1, then even/odd parity cases.
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(3);
        send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        send(1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        // Two stop bits.
        send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        // Request during DATA is ignored.
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(2);
        // Back-to-back: second request in the tx_done cycle.
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(2);
        // Reset mid-frame, then a clean frame.
        send(1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(3);
        send(1'b0, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(2);
        // Request coincident with a baud tick.
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side frame controller for the APB-UART bridge, directly upstream of the TX serializer.
- Accepts a byte-wide transmit request and latches the data, which it presents to the serializer on parallel_data.
- Sequences start, data (LSB first), optional parity and stop bits on baud ticks, driving the serializer's ser_en/frame.
- Muxes the serializer's registered serial_data with the start, parity and stop levels to form the UART TX line.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal values 2..16.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- UCLK  input  1  UART clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-UCLK strobe marking each bit-period boundary.
- tx_start  input  1  transmit request; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  byte to send; sampled with an accepted tx_start.
- par_en  input  1  1 = append parity bit; sampled with an accepted tx_start.
- par_type  input  1  0 = even, 1 = odd; sampled with an accepted tx_start.
- serial_data  input  1  registered bit returned from the serializer.
- parallel_data  output  DATA_WIDTH  latched data (data_q) to the serializer.
- ser_en  output  1  serializer load strobe.
- frame  output  $clog2(DATA_WIDTH)  bit index for the serializer.
- tx_out  output  1  UART TX line.
- tx_busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, ALIGN, START, DATA, PARITY, STOP.
- Per-state tx_out: IDLE=1, ALIGN=1, START=0, DATA=serial_data, PARITY=parity_q, STOP=1.
- tx_out is a combinational mux of state, serial_data and parity_q, all of which are registers.
- Reset (reset=0 at a UCLK edge), taking effect on the next cycle:
  - state=IDLE, bit_cnt=0, stop_cnt=0.
  - data_q=0, parity_q=0, par_en_q=0, tx_done=0.
  - Resulting outputs: tx_out=1, tx_busy=0, ser_en=0, frame=0, parallel_data=0.
  - This applies mid-frame too: the line returns to idle-high and the frame is abandoned with no tx_done.
- IDLE: on tx_start=1:
  - Latch data_q<=tx_data and par_en_q<=par_en.
  - Latch parity_q <= (^tx_data) ^ par_type.
  - Go to ALIGN. Any baud_tick in the accept cycle is ignored.
- ALIGN: on baud_tick go to START, so the start bit lasts a full bit period.
- START: on baud_tick:
  - Assert ser_en=1 and frame=0 in that same cycle.
  - bit_cnt<=0; go to DATA.
  - The serializer registers bit 0 on that edge, so serial_data is valid from the first DATA cycle.
- DATA: on baud_tick:
  - If bit_cnt<DATA_WIDTH-1: ser_en=1, frame=bit_cnt+1, bit_cnt<=bit_cnt+1, stay in DATA.
  - Else: go to PARITY if par_en_q, otherwise go to STOP with stop_cnt<=0.
- PARITY: on baud_tick go to STOP with stop_cnt<=0.
- STOP: on baud_tick:
  - If stop_cnt<STOP_BITS-1: stop_cnt<=stop_cnt+1, stay in STOP.
  - Else: go to IDLE and set tx_done<=1 for exactly one cycle, coincident with the first IDLE cycle.
- ser_en and frame are combinational from state, bit_cnt and baud_tick. Outside the strobe, ser_en=0 and frame=0.
- ser_en never asserts outside START and DATA.
- tx_start outside IDLE is ignored, with no queueing.
  - tx_start in the tx_done cycle (IDLE) is accepted, giving back-to-back frames with no gap beyond ALIGN.
- data_q, par_en_q and parity_q are stable from accept to the return to IDLE; tx_data changes mid-frame have no effect.
- Frame length from the ALIGN→START transition: 1 + DATA_WIDTH + par_en + STOP_BITS baud ticks.
- No baud_tick means the FSM holds its state indefinitely; tx_busy stays high.

Test Plan:
- 8N1: reset, baud_tick every 4 cycles, tx_start with tx_data=0xA5, par_en=0.
  - tx_out: 1 (ALIGN), 0, then 1,0,1,0,0,1,0,1, then 1 for one period. Each bit is 4 cycles.
  - ser_en fires 8 times with frame 0..7. tx_done pulses once, 40 cycles after START entry. tx_busy is low afterwards.
- Parity: 0xA5 with par_en=1, par_type=0 → parity bit 0; with par_type=1 → 1.
  - 0x07 with even parity → parity bit 1. Frame is 11 bit periods.
- STOP_BITS=2 build: 0x3C 8N2 → two full high stop periods before tx_done; tx_done pulse is 1 cycle wide.
- Busy and back-to-back requests:
  - tx_start with 0xFF during DATA is ignored; only 0x00 is transmitted, and tx_done pulses once.
  - tx_start asserted in the tx_done cycle → the second frame starts via ALIGN.
- Reset mid-frame: reset=0 for 1 cycle during DATA bit 3.
  - Next cycle: tx_out=1, tx_busy=0, ser_en=0, parallel_data=0, no tx_done.
  - A following tx_start then sends a complete, correct frame.
- Tick in accept cycle: tx_start coincident with baud_tick → FSM enters ALIGN and waits for the next baud_tick. START lasts exactly one full period.
